step_source_ctrl: RTL and testbench
===================================

Name: step_source_ctrl

Overview:
Controller that generates the single-cycle step pulse driving the lab counter datapath, choosing among a manual debounced button, a free-running divided tick, and a counted burst. It replaces the bare switch-selected clean/clock path with a sequenced source. Mode changes are deferred to safe boundaries, so no runt or double step reaches the datapath. It sits between the debouncer/switch inputs and the counter's enable.

Parameters:
DIV, 50000000, step period in clk cycles for AUTO and BURST modes (legal range ≥1)
CNT_W, 26, width of the divider counter (2^CNT_W ≥ DIV)
BURST_W, 4, width of burst_len and the remaining-step counter

Ports:
clk  input  1  system clock, all logic on posedge
rst_n  input  1  synchronous active-low reset
mode_req  input  2  requested mode: 00 MANUAL, 01 AUTO, 10 BURST, 11 reserved (treated as MANUAL)
btn_clean  input  1  debounced step button level
burst_len  input  BURST_W  number of steps per burst, sampled on button press
tick  output  1  registered single-cycle step pulse to the datapath
mode_cur  output  2  mode currently in effect (same encoding as mode_req)
busy  output  1  high while a burst runs or a mode change is pending

Behaviour:
- Reset (rst_n=0 at posedge): tick=0, mode_cur=00, busy=0, div_cnt=0, remaining=0, btn_q=1, state=S_MANUAL. A button already held at reset release produces no press. Reset mid-burst aborts the burst; no tick is issued in the cycle after reset.
- Press detection: press = btn_clean & ~btn_q. btn_q is registered every cycle.
- States: S_MANUAL, S_AUTO, S_BURST_IDLE, S_BURST_RUN. mode_cur reflects the state (both BURST states report 10).
- S_MANUAL: press → tick=1 on the next posedge (1-cycle latency), then 0. div_cnt is held at 0.
- S_AUTO: div_cnt counts 0..DIV-1 and wraps. tick=1 on the posedge following div_cnt==DIV-1, giving one tick every DIV cycles. The first tick comes DIV cycles after entry. Presses are ignored. If DIV=1, tick is high every cycle.
- S_BURST_IDLE: press with burst_len≠0 → remaining=burst_len, div_cnt=0, go to S_BURST_RUN. Press with burst_len=0 is ignored.
- S_BURST_RUN: divider runs as in AUTO. Each tick decrements remaining. The tick with remaining==1 is the last one, and the next state is S_BURST_IDLE (or the pending mode). Presses and burst_len changes are ignored. Exactly burst_len ticks are emitted, spaced DIV cycles apart.
- Mode change, when mode_req ≠ mode_cur:
  - From S_MANUAL or S_BURST_IDLE: switch on the next posedge.
  - From S_AUTO: pending until the wrap cycle (div_cnt==DIV-1). That tick is still emitted, then the switch occurs.
  - From S_BURST_RUN: pending until the burst completes.
  - Entering AUTO or BURST_RUN clears div_cnt to 0.
  - If mode_req returns to mode_cur before the switch, the pending request is cancelled.
- A press coinciding with the switch cycle is evaluated in the new state on the following cycle only if it is still a rising edge; otherwise it is dropped.
- busy = (state==S_BURST_RUN) | (mode_req≠mode_cur, after reserved→MANUAL mapping).
- Arithmetic: div_cnt and remaining are unsigned and never underflow.

Optional Feature:
STEP_TICK_COUNT_EN
- Defined: adds output tick_count[15:0]. It resets to 0, increments on every cycle tick=1, and wraps from 0xFFFF to 0.
- Undefined: the port and counter are absent, with no other change.

Decomposition:
- Shared package step_ctrl_pkg holds the mode encodings (MODE_MANUAL=2'b00, MODE_AUTO=2'b01, MODE_BURST=2'b10) and the state encodings (S_MANUAL, S_AUTO, S_BURST_IDLE, S_BURST_RUN).
- Natural sub-module: rise_detect (btn_q register plus press output, reset value 1).
- The FSM and divider stay in step_source_ctrl.

Test Plan:
- DIV=4, mode_req=00, btn_clean pulse high for 3 cycles → exactly one tick, 1 cycle after the rising edge, mode_cur=00.
- DIV=4, mode_req=01 for 20 cycles → ticks at cycles 4, 8, 12, 16, 20 after entry, each 1 cycle wide.
- DIV=4, mode_req=10, burst_len=3, press → 3 ticks 4 cycles apart, busy high until the last tick, presses during the burst ignored. Repeat with burst_len=0 → no ticks, busy=0.
- AUTO running, mode_req→00 when div_cnt==1 → busy=1, one more tick at the wrap, then mode_cur=00 and no further ticks.
- Burst of 5 in progress, assert rst_n=0 for 1 cycle → tick=0, mode_cur=00, busy=0. btn_clean held high through reset produces no tick.
- With STEP_TICK_COUNT_EN and DIV=1 in AUTO for 65537 cycles → tick_count wraps to 0 and reads 1.

Source files
------------

// File: rtl/step_ctrl_pkg.sv
// Shared encodings for the step source controller: mode codes, FSM states and
// the mapping helpers between them.
package step_ctrl_pkg;

   localparam logic [1:0] MODE_MANUAL = 2'b00;
   localparam logic [1:0] MODE_AUTO   = 2'b01;
   localparam logic [1:0] MODE_BURST  = 2'b10;

   typedef enum logic [1:0] {
      S_MANUAL     = 2'b00,
      S_AUTO       = 2'b01,
      S_BURST_IDLE = 2'b10,
      S_BURST_RUN  = 2'b11
   } state_e;

   // The reserved request code behaves exactly like MANUAL.
   function automatic logic [1:0] effMode(input logic [1:0] req);
      return (req == 2'b11) ? MODE_MANUAL : req;
   endfunction

   function automatic logic [1:0] stateMode(input state_e s);
      case (s)
         S_AUTO:                    return MODE_AUTO;
         S_BURST_IDLE, S_BURST_RUN: return MODE_BURST;
         default:                   return MODE_MANUAL;
      endcase
   endfunction

   function automatic state_e modeState(input logic [1:0] m);
      case (m)
         MODE_AUTO:  return S_AUTO;
         MODE_BURST: return S_BURST_IDLE;
         default:    return S_MANUAL;
      endcase
   endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for the debounced button; the history register resets
// high so a button held through reset never reads as a press.
module rise_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic i_level,
   output logic o_rise
);

   logic r_levelQ;

   always_ff @(posedge clk) begin
      if (!rst_n) r_levelQ <= 1'b1;
      else        r_levelQ <= i_level;
   end

   assign o_rise = i_level & ~r_levelQ;

endmodule

// File: rtl/step_source_ctrl.sv
// Step pulse source for the lab counter: manual button, divided auto tick or
// counted burst, with mode changes deferred to safe points. Define
// STEP_TICK_COUNT_EN to add the free-running tick_count output.
module step_source_ctrl
   import step_ctrl_pkg::*;
#(
   parameter int DIV     = 50000000,
   parameter int CNT_W   = 26,
   parameter int BURST_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         mode_req,
   input  logic               btn_clean,
   input  logic [BURST_W-1:0] burst_len,
   output logic               tick,
   output logic [1:0]         mode_cur,
   output logic               busy
`ifdef STEP_TICK_COUNT_EN
   ,
   output logic [15:0]        tick_count
`endif
);

   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

   state_e             r_state, w_stateNext;
   logic [CNT_W-1:0]   r_divCnt, w_divCntNext;
   logic [BURST_W-1:0] r_remaining, w_remainingNext;
   logic               r_tick, w_tickNext;
   logic               w_press, w_wrap, w_change;
   logic [1:0]         w_reqMode;
   state_e             w_target;

   rise_detect u_rise (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_level (btn_clean),
      .o_rise  (w_press)
   );

   assign w_reqMode = effMode(mode_req);
   assign w_target  = modeState(w_reqMode);
   assign mode_cur  = stateMode(r_state);
   assign w_change  = (w_reqMode != mode_cur);
   assign w_wrap    = (r_divCnt == DIV_LAST);
   assign busy      = (r_state == S_BURST_RUN) | w_change;
   assign tick      = r_tick;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_MANUAL;
         r_divCnt    <= '0;
         r_remaining <= '0;
         r_tick      <= 1'b0;
      end else begin
         r_state     <= w_stateNext;
         r_divCnt    <= w_divCntNext;
         r_remaining <= w_remainingNext;
         r_tick      <= w_tickNext;
      end
   end

   // The divider is parked at zero in the idle states, so any entry into a
   // counting state starts a full DIV-cycle period.
   always_comb begin
      w_stateNext     = r_state;
      w_divCntNext    = r_divCnt;
      w_remainingNext = r_remaining;
      w_tickNext      = 1'b0;
      case (r_state)
         S_MANUAL: begin
            w_divCntNext = '0;
            if (w_change) w_stateNext = w_target;
            else          w_tickNext  = w_press;
         end
         S_BURST_IDLE: begin
            w_divCntNext = '0;
            if (w_change) begin
               w_stateNext = w_target;
            end else if (w_press && (burst_len != '0)) begin
               w_remainingNext = burst_len;
               w_stateNext     = S_BURST_RUN;
            end
         end
         S_AUTO: begin
            if (w_wrap) begin
               w_tickNext   = 1'b1;
               w_divCntNext = '0;
               if (w_change) w_stateNext = w_target;
            end else begin
               w_divCntNext = r_divCnt + 1'b1;
            end
         end
         S_BURST_RUN: begin
            if (w_wrap) begin
               w_tickNext   = 1'b1;
               w_divCntNext = '0;
               if (r_remaining != '0) w_remainingNext = r_remaining - 1'b1;
               if (r_remaining <= BURST_W'(1))
                  w_stateNext = w_change ? w_target : S_BURST_IDLE;
            end else begin
               w_divCntNext = r_divCnt + 1'b1;
            end
         end
         default: w_stateNext = S_MANUAL;
      endcase
   end

`ifdef STEP_TICK_COUNT_EN
   logic [15:0] r_tickCount;

   always_ff @(posedge clk) begin
      if (!rst_n)      r_tickCount <= '0;
      else if (r_tick) r_tickCount <= r_tickCount + 16'd1;
   end

   assign tick_count = r_tickCount;
`endif

endmodule

// File: tb/tb_step_source_ctrl.sv
// Directed-plus-random bench for step_source_ctrl; expected tick times come
// from arithmetic on the mode rules (period DIV, burst counts, deferred switch).
module tb_step_source_ctrl;

   localparam int TB_DIV = 4;

   logic       clk = 1'b0;
   logic       rst_n, btnClean, btnClean1;
   logic [1:0] modeReq, modeReq1;
   logic [3:0] burstLen;
   logic       tick, busy, tick1, busy1;
   logic [1:0] modeCur, modeCur1;
`ifdef STEP_TICK_COUNT_EN
   logic [15:0] tickCount, tickCount1;
`endif

   int   checkCount = 0;
   int   passCount  = 0;
   int   expTickCnt = 0;
   logic btnPrev    = 1'b1;

   always #5 clk = ~clk;

   step_source_ctrl #(.DIV(TB_DIV), .CNT_W(8), .BURST_W(4)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode_req  (modeReq),
      .btn_clean (btnClean),
      .burst_len (burstLen),
      .tick      (tick),
      .mode_cur  (modeCur),
      .busy      (busy)
`ifdef STEP_TICK_COUNT_EN
      ,
      .tick_count(tickCount)
`endif
   );

   step_source_ctrl #(.DIV(1), .CNT_W(4), .BURST_W(4)) u_dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode_req  (modeReq1),
      .btn_clean (btnClean1),
      .burst_len (4'd0),
      .tick      (tick1),
      .mode_cur  (modeCur1),
      .busy      (busy1)
`ifdef STEP_TICK_COUNT_EN
      ,
      .tick_count(tickCount1)
`endif
   );

   function automatic logic [1:0] effMode(input logic [1:0] m);
      return (m == 2'b11) ? 2'b00 : m;
   endfunction

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic applyStimulus(input logic r, input logic [1:0] m, input logic b, input logic [3:0] len);
      rst_n    = r;
      modeReq  = m;
      btnClean = b;
      burstLen = len;
   endtask

   task automatic checkBusy(input string tag, input logic exp);
      #1;
      checkOutput(tag, {15'd0, busy}, {15'd0, exp});
   endtask

   // One clock: sample just after the edge, compare tick/mode (and tick_count).
   task automatic checkCycle(input string tag, input logic expTick, input logic [1:0] expMode);
      @(posedge clk);
      #1;
`ifdef STEP_TICK_COUNT_EN
      if (!rst_n) expTickCnt = 0;
      checkOutput({tag, "_cnt"}, tickCount, 16'(expTickCnt));
`endif
      checkOutput({tag, "_tick"}, {15'd0, tick}, {15'd0, expTick});
      checkOutput({tag, "_mode"}, {14'd0, modeCur}, {14'd0, expMode});
      if (expTick) expTickCnt++;
   endtask

   // From MANUAL: enter AUTO, optionally bounce a request (cancel), then request
   // reqVal after sample reqAt; the switch lands on the next multiple of DIV.
   task automatic autoRun(input int cReq, input int reqAt, input logic [1:0] reqVal);
      int         switchAt;
      logic [1:0] curM, shown, expMode;
      logic       b;
      switchAt = (reqAt / TB_DIV + 1) * TB_DIV;
      applyStimulus(1'b1, 2'b01, 1'b0, burstLen);
      checkBusy("autoReq_busy", 1'b1);
      checkCycle("autoEntry", 1'b0, 2'b01);
      curM  = 2'b01;
      shown = 2'b01;
      for (int i = 1; i <= switchAt + 6; i++) begin
         if (cReq > 0 && i == cReq + 1) curM = 2'b00;
         if (cReq > 0 && i == cReq + 2) curM = 2'b01;
         if (i == reqAt + 1) curM = reqVal;
         b = (i < switchAt) ? 1'($urandom_range(0, 1)) : 1'b0;
         applyStimulus(1'b1, curM, b, 4'($urandom));
         checkBusy("auto_busy", effMode(curM) != shown);
         expMode = (i < switchAt) ? 2'b01 : 2'b00;
         checkCycle("auto", (i % TB_DIV == 0) && (i <= switchAt), expMode);
         shown = expMode;
      end
      btnPrev = 1'b0;
   endtask

   // From BURST idle with the button low: press with len, expect len ticks
   // DIV apart; an optional request after sample reqAt takes effect at the end.
   task automatic burstRun(input int len, input int reqAt, input logic [1:0] reqVal);
      int         last;
      logic [1:0] curM, shown, expMode;
      logic       inRun, b, expTick;
      applyStimulus(1'b1, 2'b10, 1'b1, 4'(len));
      checkBusy("burstPress_busy", 1'b0);
      checkCycle("burstPress", 1'b0, 2'b10);
      last  = (len == 0) ? 1 : 1 + TB_DIV * len;
      curM  = 2'b10;
      shown = 2'b10;
      inRun = (len != 0);
      for (int i = 2; i <= last + 2 * TB_DIV + 1; i++) begin
         if (reqAt > 0 && i == reqAt + 1) curM = reqVal;
         b = ((len == 0 && i < 8) || i < last - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
         applyStimulus(1'b1, curM, b, (len == 0) ? 4'd0 : 4'($urandom));
         checkBusy("burst_busy", inRun | (effMode(curM) != shown));
         expTick = (len != 0) && ((i - 1) % TB_DIV == 0) && (i <= last);
         expMode = (i < last) ? 2'b10 : effMode(curM);
         checkCycle("burst", expTick, expMode);
         shown = expMode;
         inRun = (len != 0) && (i < last);
      end
      btnPrev = 1'b0;
   endtask

   initial begin
      int   w, g, len2, req2;
      logic lvl;
      modeReq1  = 2'b00;
      btnClean1 = 1'b0;

      // Reset with the button held, then release: no press may be seen.
      applyStimulus(1'b0, 2'b00, 1'b1, 4'd0);
      checkCycle("reset", 1'b0, 2'b00);
      checkCycle("reset", 1'b0, 2'b00);
      checkBusy("reset_busy", 1'b0);
      applyStimulus(1'b1, 2'b00, 1'b1, 4'd0);
      repeat (3) checkCycle("heldBtn", 1'b0, 2'b00);
      applyStimulus(1'b1, 2'b00, 1'b0, 4'd0);
      checkCycle("btnLow", 1'b0, 2'b00);
      btnPrev = 1'b0;

      // Manual: one tick one cycle after each rising edge of the button.
      for (int p = 0; p < 7; p++) begin
         w = (p == 0) ? 3 : $urandom_range(1, 4);
         g = (p == 0) ? 2 : $urandom_range(1, 3);
         for (int k = 0; k < w + g; k++) begin
            lvl = (k < w);
            applyStimulus(1'b1, 2'b00, lvl, 4'($urandom));
            checkCycle("manual", lvl & ~btnPrev, 2'b00);
            btnPrev = lvl;
         end
      end

      // Auto: exit requested at div_cnt==1; then a cancelled request and a
      // reserved-code exit at a random phase.
      autoRun(0, 21, 2'b00);
      autoRun(5, 12 + $urandom_range(0, 3), 2'b11);

      // Burst mode entry and bursts of various lengths.
      applyStimulus(1'b1, 2'b10, 1'b0, 4'd0);
      checkBusy("burstReq_busy", 1'b1);
      checkCycle("burstEnter", 1'b0, 2'b10);
      burstRun(3, 0, 2'b00);
      burstRun($urandom_range(1, 15), 0, 2'b00);
      burstRun(0, 0, 2'b00);
      len2 = $urandom_range(2, 6);
      req2 = $urandom_range(2, TB_DIV * len2);
      burstRun(len2, req2, 2'b00);

      // Reset in the cycle a burst tick would have fired, button held.
      applyStimulus(1'b1, 2'b10, 1'b0, 4'd5);
      checkCycle("burstEnter2", 1'b0, 2'b10);
      applyStimulus(1'b1, 2'b10, 1'b1, 4'd5);
      checkCycle("burst5Press", 1'b0, 2'b10);
      for (int i = 0; i < TB_DIV - 1; i++) begin
         applyStimulus(1'b1, 2'b10, 1'b0, 4'd5);
         checkBusy("burst5_busy", 1'b1);
         checkCycle("burst5", 1'b0, 2'b10);
      end
      applyStimulus(1'b0, 2'b00, 1'b1, 4'd5);
      checkCycle("midReset", 1'b0, 2'b00);
      checkBusy("midReset_busy", 1'b0);
      applyStimulus(1'b1, 2'b00, 1'b1, 4'd0);
      repeat (4) checkCycle("postReset", 1'b0, 2'b00);
      applyStimulus(1'b1, 2'b00, 1'b0, 4'd0);
      checkCycle("postReset", 1'b0, 2'b00);
      applyStimulus(1'b1, 2'b00, 1'b1, 4'd0);
      checkCycle("postPress", 1'b1, 2'b00);
      applyStimulus(1'b1, 2'b00, 1'b0, 4'd0);
      checkCycle("postPress", 1'b0, 2'b00);

      // DIV=1 instance: auto ticks every cycle after entry.
      modeReq1 = 2'b01;
      #1;
      checkOutput("div1Req_busy", {15'd0, busy1}, 16'd1);
      for (int n = 0; n < 8; n++) begin
         @(posedge clk);
         #1;
         checkOutput("div1_tick", {15'd0, tick1}, (n > 0) ? 16'd1 : 16'd0);
         checkOutput("div1_mode", {14'd0, modeCur1}, 16'd1);
      end
`ifdef STEP_TICK_COUNT_EN
      // Sample n after entry has seen n-1 ticks counted.
      for (int n = 8; n <= 65538; n++) begin
         @(posedge clk);
         #1;
         if (n == 65537) checkOutput("div1_cntWrap", tickCount1, 16'd0);
         if (n == 65538) checkOutput("div1_cntOne", tickCount1, 16'd1);
      end
`endif

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
